// File: rtl/ysyx_axi4_master.sv
// Single-outstanding AXI4 master: turns a simple request/response port into AR/R or AW/W/B bursts.
// Responses are combinational from R/B handshakes; req_ready only while idle.
module ysyx_axi4_master #(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,

    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [XLEN-1:0] req_addr,
    input  logic [2:0]      req_size,
    input  logic [7:0]      req_len,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [3:0]      req_wstrb,

    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_last,
    output logic            rsp_err,

    output logic            arvalid,
    input  logic            arready,
    output logic [XLEN-1:0] araddr,
    output logic [7:0]      arlen,
    output logic [2:0]      arsize,
    output logic [1:0]      arburst,
    output logic [3:0]      arid,

    input  logic            rvalid,
    output logic            rready,
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      rresp,
    input  logic            rlast,
    input  logic [3:0]      rid,

    output logic            awvalid,
    input  logic            awready,
    output logic [XLEN-1:0] awaddr,
    output logic [7:0]      awlen,
    output logic [2:0]      awsize,
    output logic [1:0]      awburst,
    output logic [3:0]      awid,

    output logic            wvalid,
    input  logic            wready,
    output logic [XLEN-1:0] wdata,
    output logic [3:0]      wstrb,
    output logic            wlast,

    input  logic            bvalid,
    output logic            bready,
    input  logic [1:0]      bresp,
    input  logic [3:0]      bid
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] RADDR = 3'd1;
    localparam logic [2:0] RDATA = 3'd2;
    localparam logic [2:0] WREQ  = 3'd3;
    localparam logic [2:0] WRESP = 3'd4;

    logic [2:0]      r_state;
    logic [XLEN-1:0] r_addr;
    logic [2:0]      r_size;
    logic [7:0]      r_len;
    logic [XLEN-1:0] r_wdata;
    logic [3:0]      r_wstrb;
    logic            r_aw_done;
    logic            r_w_done;

    logic w_rbeat;
    logic w_bresp;
    logic w_aw_fire;
    logic w_w_fire;
    logic w_aw_next;
    logic w_w_next;
    logic w_unused;

    // IDs are single-valued here, so returned IDs carry no information.
    assign w_unused = ^{rid, bid};

    // Valid/ready outputs are gated by reset so they drop in the same cycle reset rises.
    assign req_ready = ~reset & (r_state == IDLE);
    assign arvalid   = ~reset & (r_state == RADDR);
    assign rready    = ~reset & (r_state == RDATA);
    assign awvalid   = ~reset & (r_state == WREQ) & ~r_aw_done;
    assign wvalid    = ~reset & (r_state == WREQ) & ~r_w_done;
    assign bready    = ~reset & (r_state == WRESP);

    assign w_rbeat   = rready & rvalid;
    assign w_bresp   = bready & bvalid;
    assign w_aw_fire = awvalid & awready;
    assign w_w_fire  = wvalid & wready;
    assign w_aw_next = r_aw_done | w_aw_fire;
    assign w_w_next  = r_w_done | w_w_fire;

    assign rsp_valid = w_rbeat | w_bresp;
    assign rsp_rdata = w_rbeat ? rdata : '0;
    assign rsp_last  = (w_rbeat & rlast) | w_bresp;
    assign rsp_err   = (w_rbeat & (rresp != 2'b00)) | (w_bresp & (bresp != 2'b00));

    assign araddr  = r_addr;
    assign arlen   = r_len;
    assign arsize  = r_size;
    assign arburst = 2'b01;
    assign arid    = 4'd0;
    assign awaddr  = r_addr;
    assign awlen   = 8'd0;
    assign awsize  = r_size;
    assign awburst = 2'b01;
    assign awid    = 4'd0;
    assign wdata   = r_wdata;
    assign wstrb   = r_wstrb;
    assign wlast   = 1'b1;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= IDLE;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_addr    <= '0;
            r_size    <= 3'd0;
            r_len     <= 8'd0;
            r_wdata   <= '0;
            r_wstrb   <= 4'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_addr    <= req_addr;
                        r_size    <= req_size;
                        r_len     <= req_we ? 8'd0 : req_len;
                        r_wdata   <= req_wdata;
                        r_wstrb   <= req_wstrb;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_state   <= req_we ? WREQ : RADDR;
                    end
                end
                RADDR: begin
                    if (arready) r_state <= RDATA;
                end
                RDATA: begin
                    if (w_rbeat && rlast) r_state <= IDLE;
                end
                WREQ: begin
                    // AW and W complete independently; both must land before waiting on B.
                    if (w_aw_next && w_w_next) begin
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_state   <= WRESP;
                    end else begin
                        r_aw_done <= w_aw_next;
                        r_w_done  <= w_w_next;
                    end
                end
                WRESP: begin
                    if (w_bresp) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/ysyx_axi4_master.md
YSYX_AXI4_MASTER -- requirements
Module: ysyx_axi4_master

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data/address width; only 32 is supported.
REQ-002 SHALL have clock  in  1  clock; all state changes on its rising edge.
REQ-003 SHALL have reset  in  1  reset, synchronous, active-high.
REQ-004 SHALL have req_valid  in  1  upstream request valid.
REQ-005 SHALL have req_ready  out  1  request accepted when req_valid & req_ready.
REQ-006 SHALL have req_we  in  1  1 = write, 0 = read.
REQ-007 SHALL have req_addr  in  XLEN  byte address.
REQ-008 SHALL have req_size  in  3  AXI size code (0/1/2).
REQ-009 SHALL have req_len  in  8  read beats minus 1; ignored for writes.
REQ-010 SHALL have req_wdata  in  XLEN  write data.
REQ-011 SHALL have req_wstrb  in  4  write byte strobes.
REQ-012 SHALL have rsp_valid  out  1  one-cycle response pulse, no backpressure.
REQ-013 SHALL have rsp_rdata  out  XLEN  read beat data (0 for writes).
REQ-014 SHALL have rsp_last  out  1  final response of the transaction.
REQ-015 SHALL have rsp_err  out  1  xresp != 0 on this beat/response.
REQ-016 SHALL have the AXI4 master AR channel: arvalid out 1, arready in 1, araddr out XLEN, arlen out 8, arsize out 3, arburst out 2, arid out 4.
REQ-017 SHALL have the R channel: rvalid in 1, rready out 1, rdata in XLEN, rresp in 2, rlast in 1, rid in 4 (ignored).
REQ-018 SHALL have the AW channel: awvalid out 1, awready in 1, awaddr out XLEN, awlen out 8, awsize out 3, awburst out 2, awid out 4.
REQ-019 SHALL have the W channel: wvalid out 1, wready in 1, wdata out XLEN, wstrb out 4, wlast out 1.
REQ-020 SHALL have the B channel: bvalid in 1, bready out 1, bresp in 2, bid in 4 (ignored).

Function
REQ-021 SHALL use states IDLE, RADDR, RDATA, WREQ, WRESP; at most one outstanding transaction.
REQ-022 SHALL assert req_ready only in IDLE, not while reset is high.
REQ-023 SHALL on a read handshake latch addr/size/len and enter RADDR the next cycle, driving arvalid=1.
REQ-024 SHALL hold arvalid and all AR fields stable until arready; on arvalid&arready go to RDATA.
REQ-025 SHALL drive rready=1 only in RDATA; each rvalid&rready emits rsp_valid the same cycle with rsp_rdata=rdata, rsp_err=(rresp!=0), rsp_last=rlast.
REQ-026 SHALL return to IDLE after the beat with rlast=1; beats beyond arlen+1 without rlast are not checked.
REQ-027 SHALL on a write handshake latch addr/size/wdata/wstrb and enter WREQ, asserting awvalid and wvalid together the next cycle.
REQ-028 SHALL in WREQ track aw_done and w_done independently; deassert each valid after its own handshake, in any order or the same cycle.
REQ-029 SHALL enter WRESP when both aw and w handshakes have completed; bready=1 only in WRESP.
REQ-030 SHALL on bvalid&bready pulse rsp_valid with rsp_last=1, rsp_err=(bresp!=0), rsp_rdata=0, then go to IDLE.
REQ-031 SHALL drive constants: arid=awid=0, arburst=awburst=2'b01 (INCR), awlen=0, wlast=1.
REQ-032 SHALL drive araddr/awaddr as the latched address unaligned-unmodified; size code passed through.
REQ-033 SHALL keep latched fields unchanged while the transaction is in flight, regardless of req_* activity.
REQ-034 SHALL complete a transaction in minimum 3 cycles from request handshake to rsp_valid (accept, addr handshake, data/resp).

Reset
REQ-035 SHALL on reset force IDLE and clear aw_done/w_done; arvalid, awvalid, wvalid, rready, bready, rsp_valid, rsp_last, rsp_err =0, req_ready=0 during reset.
REQ-036 SHALL abandon any in-flight transaction on reset mid-operation without emitting rsp_valid.

Verification
REQ-037 Read len=0, addr 0x8000_0004, arready/rvalid immediate, rdata 0xDEADBEEF, rlast=1 -> araddr=0x8000_0004, arlen=0, one rsp_valid with rsp_rdata=0xDEADBEEF, rsp_last=1, rsp_err=0.
REQ-038 Read len=3, slave returns 4 beats 0x1..0x4, rvalid gapped -> four rsp_valid pulses in order, rsp_last only on 0x4, then req_ready=1.
REQ-039 Write addr 0xA000_03F8, wdata 0x41, wstrb 4'b0001, awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid held 3 cycles, bready only after both, one rsp_valid, rsp_last=1.
REQ-040 Write with bresp=2'b10 -> rsp_err=1; read beat with rresp=2'b11 -> rsp_err=1 on that beat only.
REQ-041 Reset asserted in RDATA after 1 of 4 beats -> next cycle all valids 0, no further rsp_valid, req_ready=1 after reset release.
REQ-042 req_valid held high with changing req_addr during a read -> araddr stays at the accepted value until arready.
